// File: rtl/xlr_mem_pkg.sv
// Shared types and constants for the XBOX accelerator memory arbiter.
// Line format: 8 words of 32 bits, one byte enable per byte.
package xlr_mem_pkg;

    localparam int XLR_WORDS  = 8;
    localparam int XLR_WORD_W = 32;
    localparam int XLR_BE_W   = 32;

    typedef logic [XLR_WORDS-1:0][XLR_WORD_W-1:0] xlr_line_t;

    typedef enum logic {
        FREE,
        OWNED
    } lock_state_e;

    // Select width that stays legal when there is only one target.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xlr_mem_arb_if.sv
// Engine-side command/response bus plus memory-side port bundle of the arbiter.
// master = engines and memories (the environment), slave = the arbiter.
interface xlr_mem_arb_if
    import xlr_mem_pkg::*;
#(
    parameter int NUM_REQ            = 2,
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8
);
    localparam int MEM_W = sel_w(NUM_MEMS);

    logic      [NUM_REQ-1:0]                          req_vld;
    logic      [NUM_REQ-1:0][MEM_W-1:0]               req_mem;
    logic      [NUM_REQ-1:0][LOG2_LINES_PER_MEM-1:0]  req_addr;
    logic      [NUM_REQ-1:0]                          req_rd;
    logic      [NUM_REQ-1:0]                          req_wr;
    xlr_line_t [NUM_REQ-1:0]                          req_wdata;
    logic      [NUM_REQ-1:0][XLR_BE_W-1:0]            req_be;
    logic      [NUM_REQ-1:0]                          req_lock;
    logic      [NUM_REQ-1:0]                          req_gnt;
    logic      [NUM_REQ-1:0]                          rsp_vld;
    xlr_line_t [NUM_REQ-1:0]                          rsp_rdata;
    logic                                             err;

    logic      [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0] xlr_mem_addr;
    xlr_line_t [NUM_MEMS-1:0]                         xlr_mem_wdata;
    logic      [NUM_MEMS-1:0][XLR_BE_W-1:0]           xlr_mem_be;
    logic      [NUM_MEMS-1:0]                         xlr_mem_rd;
    logic      [NUM_MEMS-1:0]                         xlr_mem_wr;
    xlr_line_t [NUM_MEMS-1:0]                         xlr_mem_rdata;

    modport master (
        output req_vld, req_mem, req_addr, req_rd, req_wr, req_wdata, req_be, req_lock,
        input  req_gnt, rsp_vld, rsp_rdata, err,
        input  xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
        output xlr_mem_rdata
    );

    modport slave (
        input  req_vld, req_mem, req_addr, req_rd, req_wr, req_wdata, req_be, req_lock,
        output req_gnt, rsp_vld, rsp_rdata, err,
        output xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
        input  xlr_mem_rdata
    );

endinterface

// File: rtl/xlr_rr_arb.sv
// Per-memory round-robin arbiter with lock ownership; one-hot grant in the request cycle.
// Latency: combinational grant; backpressure: losers and non-owners stall until granted.
module xlr_rr_arb
    import xlr_mem_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] cand,
    input  logic [NUM_REQ-1:0] lock,
    input  logic [NUM_REQ-1:0] vld,
    output logic [NUM_REQ-1:0] gnt
);
    localparam int IDX_W = sel_w(NUM_REQ);

    lock_state_e      state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FREE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        gnt     = '0;
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        idx     = '0;
        found   = 1'b0;
        if (!rst) begin
            if (state_q == OWNED) begin
                // Owner keeps the memory; a cycle without its valid releases it.
                if (cand[owner_q]) begin
                    gnt[owner_q] = 1'b1;
                    ptr_d        = owner_q;
                    if (!lock[owner_q]) state_d = FREE;
                end else if (!vld[owner_q]) begin
                    state_d = FREE;
                end
            end else begin
                for (int i = 1; i <= NUM_REQ; i++) begin
                    idx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
                    if (!found && cand[idx]) begin
                        found    = 1'b1;
                        gnt[idx] = 1'b1;
                        ptr_d    = idx;
                        if (lock[idx]) begin
                            state_d = OWNED;
                            owner_d = idx;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/xlr_mem_arb.sv
// Shares NUM_MEMS accelerator memories among NUM_REQ engines; each memory arbitrated independently.
// Latency: grant and memory strobes same cycle, read data 1 cycle later; backpressure: req held until req_gnt.
module xlr_mem_arb
    import xlr_mem_pkg::*;
#(
    parameter int NUM_REQ            = 2,
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8
) (
    input  logic          clk,
    input  logic          rst,
    xlr_mem_arb_if.slave  bus
);
    localparam int MEM_W = sel_w(NUM_MEMS);

    logic      [NUM_MEMS-1:0][NUM_REQ-1:0]            cand;
    logic      [NUM_MEMS-1:0][NUM_REQ-1:0]            mem_gnt;
    logic      [NUM_REQ-1:0]                          gnt;
    logic      [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0] mem_addr;
    xlr_line_t [NUM_MEMS-1:0]                         mem_wdata;
    logic      [NUM_MEMS-1:0][XLR_BE_W-1:0]           mem_be;
    logic      [NUM_MEMS-1:0]                         mem_rd;
    logic      [NUM_MEMS-1:0]                         mem_wr;
    logic      [NUM_REQ-1:0]                          rd_pend_q;
    logic      [NUM_REQ-1:0][MEM_W-1:0]               rd_mem_q;
    logic      [NUM_REQ-1:0]                          illegal;
    logic                                             bad_mem;
    logic                                             err_q;

    // Out-of-range targets match no memory, so they are never granted.
    always_comb begin
        cand = '0;
        for (int m = 0; m < NUM_MEMS; m++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                cand[m][r] = bus.req_vld[r] && (bus.req_mem[r] == MEM_W'(m));
            end
        end
    end

    for (genvar m = 0; m < NUM_MEMS; m++) begin : g_arb
        xlr_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
            .clk  (clk),
            .rst  (rst),
            .cand (cand[m]),
            .lock (bus.req_lock),
            .vld  (bus.req_vld),
            .gnt  (mem_gnt[m])
        );
    end

    always_comb begin
        gnt       = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        mem_rd    = '0;
        mem_wr    = '0;
        for (int m = 0; m < NUM_MEMS; m++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (mem_gnt[m][r]) begin
                    gnt[r]       = 1'b1;
                    mem_addr[m]  = bus.req_addr[r];
                    mem_wdata[m] = bus.req_wdata[r];
                    mem_be[m]    = bus.req_be[r];
                    // rd+wr together is treated as a write.
                    mem_rd[m]    = bus.req_rd[r] && !bus.req_wr[r];
                    mem_wr[m]    = bus.req_wr[r];
                end
            end
        end
    end

    assign bus.req_gnt       = gnt;
    assign bus.xlr_mem_addr  = mem_addr;
    assign bus.xlr_mem_wdata = mem_wdata;
    assign bus.xlr_mem_be    = mem_be;
    assign bus.xlr_mem_rd    = mem_rd;
    assign bus.xlr_mem_wr    = mem_wr;
    assign bus.err           = err_q;

    always_comb begin
        illegal = '0;
        bad_mem = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            illegal[r] = gnt[r] && (bus.req_rd[r] == bus.req_wr[r]);
            if (bus.req_vld[r] && (int'(bus.req_mem[r]) >= NUM_MEMS)) bad_mem = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= '0;
            rd_mem_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                rd_pend_q[r] <= gnt[r] && bus.req_rd[r] && !bus.req_wr[r];
                if (gnt[r]) rd_mem_q[r] <= bus.req_mem[r];
            end
            if ((|illegal) || bad_mem) err_q <= 1'b1;
        end
    end

    // Gating with rst drops a read whose data would land during reset.
    always_comb begin
        bus.rsp_vld   = '0;
        bus.rsp_rdata = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!rst && rd_pend_q[r]) begin
                bus.rsp_vld[r]   = 1'b1;
                bus.rsp_rdata[r] = bus.xlr_mem_rdata[rd_mem_q[r]];
            end
        end
    end

endmodule
